// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD seconds timer.
`timescale 1ns/1ps
package bcd_timer_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} timer_state_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    // Non-decimal nibbles (A-F) saturate to 9.
    function automatic bcd_t bcd_clamp(input bcd_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit register: up/down step with carry/borrow, clamped load and clear.
`timescale 1ns/1ps
module bcd_digit
    import bcd_timer_pkg::*;
(
    input  logic clk_1s,
    input  logic en,
    input  logic dir,
    input  logic ld,
    input  bcd_t ld_val,
    input  logic clr,
    output bcd_t q,
    output logic carry_out
);

    bcd_t q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = BCD_MIN;
        end else if (ld) begin
            q_d = bcd_clamp(ld_val);
        end else if (en) begin
            if (dir) begin
                q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
            end else begin
                q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_1s) begin
        q_q <= q_d;
    end

    assign q = q_q;
    // Carry when counting up, borrow when counting down: the digit is at its wrap point.
    assign carry_out = dir ? (q_q == BCD_MIN) : (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_timer_n.sv
// N-digit BCD seconds timer with wrap/stop modes and a terminal-count pulse.
// Optional lap hold on disp is enabled by defining BCD_TIMER_LAP_EN.
`timescale 1ns/1ps
module bcd_timer_n
    import bcd_timer_pkg::*;
#(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned W      = 4 * DIGITS
) (
    input  logic         clk_1s,
    input  logic         reset,
    input  logic         start,
    input  logic         pause,
    input  logic         dir,
    input  logic         wrap,
    input  logic         load,
    input  logic [W-1:0] load_val,
`ifdef BCD_TIMER_LAP_EN
    input  logic         lap,
`endif
    output logic [W-1:0] count,
    output logic [W-1:0] disp,
    output logic         over,
    output logic         running
);

    timer_state_t state_q, state_d;
    logic         over_q, over_d;
    logic         running_q, running_d;

    logic              step_req;
    logic              at_term;
    logic              stop_hit;
    logic [DIGITS-1:0] carry;
    logic [DIGITS:0]   en_chain;

    // Stepping happens on the same edge that enters or re-enters RUN.
    assign step_req = ~reset & ~load & ~pause & start & (state_q != DONE);
    assign at_term  = &carry;
    assign stop_hit = step_req & at_term & ~wrap;

    assign en_chain[0] = step_req & ~stop_hit;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign en_chain[i+1] = en_chain[i] & carry[i];

        bcd_digit u_digit (
            .clk_1s    (clk_1s),
            .en        (en_chain[i]),
            .dir       (dir),
            .ld        (load),
            .ld_val    (load_val[4*i +: 4]),
            .clr       (reset),
            .q         (count[4*i +: 4]),
            .carry_out (carry[i])
        );
    end

    always_ff @(posedge clk_1s) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (reset || load) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (step_req) state_d = stop_hit ? DONE : RUN;
                RUN: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (!start) begin
                        state_d = IDLE;
                    end else if (stop_hit) begin
                        state_d = DONE;
                    end
                end
                PAUSED:  if (step_req) state_d = stop_hit ? DONE : RUN;
                DONE:    state_d = DONE;
            endcase
        end
    end

    always_comb begin
        over_d    = step_req & at_term;
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk_1s) begin
        over_q    <= over_d;
        running_q <= running_d;
    end

    assign over    = over_q;
    assign running = running_q;

`ifdef BCD_TIMER_LAP_EN
    logic         lap_q, lap_d;
    logic         hold_flag_q, hold_flag_d;
    logic [W-1:0] hold_q, hold_d;

    always_comb begin
        lap_d       = reset ? 1'b0 : lap;
        hold_flag_d = hold_flag_q;
        hold_d      = hold_q;
        if (reset) begin
            hold_flag_d = 1'b0;
            hold_d      = '0;
        end else if (load) begin
            hold_flag_d = 1'b0;
        end else if (lap && !lap_q) begin
            hold_flag_d = ~hold_flag_q;
            if (!hold_flag_q) hold_d = count;
        end
    end

    always_ff @(posedge clk_1s) begin
        lap_q       <= lap_d;
        hold_flag_q <= hold_flag_d;
        hold_q      <= hold_d;
    end

    assign disp = hold_flag_q ? hold_q : count;
`else
    assign disp = count;
`endif

endmodule

// File: tb/tb_bcd_timer_n.sv
// Directed bench for bcd_timer_n: 2-digit and 3-digit instances share control inputs.
`timescale 1ns/1ps
module tb_bcd_timer_n;

    logic        clk_1s;
    logic        reset, start, pause, dir, wrap, load, lap;
    logic [7:0]  lv2;
    logic [11:0] lv3;
    logic [7:0]  count2, disp2;
    logic [11:0] count3, disp3;
    logic        over2, running2, over3, running3;

    int n_vec;
    int n_err;

    bcd_timer_n #(.DIGITS(2)) u_dut2 (
        .clk_1s   (clk_1s),
        .reset    (reset),
        .start    (start),
        .pause    (pause),
        .dir      (dir),
        .wrap     (wrap),
        .load     (load),
        .load_val (lv2),
`ifdef BCD_TIMER_LAP_EN
        .lap      (lap),
`endif
        .count    (count2),
        .disp     (disp2),
        .over     (over2),
        .running  (running2)
    );

    bcd_timer_n #(.DIGITS(3)) u_dut3 (
        .clk_1s   (clk_1s),
        .reset    (reset),
        .start    (start),
        .pause    (pause),
        .dir      (dir),
        .wrap     (wrap),
        .load     (load),
        .load_val (lv3),
`ifdef BCD_TIMER_LAP_EN
        .lap      (lap),
`endif
        .count    (count3),
        .disp     (disp3),
        .over     (over3),
        .running  (running3)
    );

    initial clk_1s = 1'b0;
    always #5 clk_1s = ~clk_1s;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_1s);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        load  = 1'b0;
        lap   = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    logic [11:0] exp3 [6];
    logic [7:0]  exp_bcd;

    initial begin
        n_vec = 0;
        n_err = 0;
        dir   = 1'b0;
        wrap  = 1'b1;
        lv2   = 8'h00;
        lv3   = 12'h000;
        exp3  = '{12'h004, 12'h003, 12'h002, 12'h001, 12'h000, 12'h000};

        apply_reset();
        check("rst_count", {24'd0, count2}, 32'h0);
        check("rst_disp", {24'd0, disp2}, 32'h0);
        check("rst_over", {31'd0, over2}, 32'h0);
        check("rst_running", {31'd0, running2}, 32'h0);

        // Up, wrap: 100 ticks return to 00 with a single over pulse.
        start = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            exp_bcd = {4'((i % 100) / 10), 4'(i % 10)};
            check("up_wrap_count", {24'd0, count2}, {24'd0, exp_bcd});
            check("up_wrap_over", {31'd0, over2}, {31'd0, (i == 100)});
            check("up_wrap_running", {31'd0, running2}, 32'h1);
        end

        // Down, stop, 3 digits.
        apply_reset();
        dir  = 1'b1;
        wrap = 1'b0;
        lv3  = 12'h005;
        load = 1'b1;
        tick();
        check("dn_load", {20'd0, count3}, 32'h005);
        check("dn_load_running", {31'd0, running3}, 32'h0);
        load  = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("dn_count", {20'd0, count3}, {20'd0, exp3[k]});
            check("dn_over", {31'd0, over3}, {31'd0, (k == 5)});
            check("dn_running", {31'd0, running3}, {31'd0, (k < 5)});
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            check("dn_hold_count", {20'd0, count3}, 32'h000);
            check("dn_hold_over", {31'd0, over3}, 32'h0);
            check("dn_hold_running", {31'd0, running3}, 32'h0);
        end

        // Pause mid-run; start stays high throughout.
        apply_reset();
        dir  = 1'b0;
        wrap = 1'b1;
        lv2  = 8'h36;
        load = 1'b1;
        tick();
        load  = 1'b0;
        start = 1'b1;
        tick();
        check("ps_run", {24'd0, count2}, 32'h37);
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("ps_hold", {24'd0, count2}, 32'h37);
            check("ps_running", {31'd0, running2}, 32'h0);
        end
        pause = 1'b0;
        tick();
        check("ps_resume", {24'd0, count2}, 32'h38);
        check("ps_resume_running", {31'd0, running2}, 32'h1);
        dir = 1'b1;
        tick();
        check("dir_change", {24'd0, count2}, 32'h37);
        lv2  = 8'h10;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        check("borrow", {24'd0, count2}, 32'h09);

        // Load clamp and priority.
        dir  = 1'b0;
        lv2  = 8'hA3;
        load = 1'b1;
        tick();
        check("clamp_a3", {24'd0, count2}, 32'h93);
        check("clamp_running", {31'd0, running2}, 32'h0);
        check("clamp_over", {31'd0, over2}, 32'h0);
        lv2 = 8'hFC;
        tick();
        check("clamp_fc", {24'd0, count2}, 32'h99);
        reset = 1'b1;
        lv2   = 8'h45;
        tick();
        check("rst_over_load", {24'd0, count2}, 32'h00);
        reset = 1'b0;
        load  = 1'b0;
        start = 1'b0;

        // Up, stop: DONE then reset; then reset mid-run at 58.
        wrap = 1'b0;
        lv2  = 8'h98;
        load = 1'b1;
        tick();
        load  = 1'b0;
        start = 1'b1;
        tick();
        check("stop_99", {24'd0, count2}, 32'h99);
        check("stop_pre_over", {31'd0, over2}, 32'h0);
        tick();
        check("stop_hold", {24'd0, count2}, 32'h99);
        check("stop_over", {31'd0, over2}, 32'h1);
        check("stop_running", {31'd0, running2}, 32'h0);
        tick();
        check("stop_over_once", {31'd0, over2}, 32'h0);
        reset = 1'b1;
        tick();
        check("done_rst_count", {24'd0, count2}, 32'h0);
        check("done_rst_disp", {24'd0, disp2}, 32'h0);
        check("done_rst_over", {31'd0, over2}, 32'h0);
        check("done_rst_running", {31'd0, running2}, 32'h0);
        reset = 1'b0;
        start = 1'b0;
        lv2   = 8'h57;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        start = 1'b1;
        tick();
        check("run_58", {24'd0, count2}, 32'h58);
        check("run_58_running", {31'd0, running2}, 32'h1);
        reset = 1'b1;
        tick();
        check("run_rst_count", {24'd0, count2}, 32'h0);
        check("run_rst_running", {31'd0, running2}, 32'h0);
        reset = 1'b0;
        tick();
        check("restart_01", {24'd0, count2}, 32'h01);
        check("restart_running", {31'd0, running2}, 32'h1);

`ifdef BCD_TIMER_LAP_EN
        apply_reset();
        wrap = 1'b1;
        lv2  = 8'h11;
        load = 1'b1;
        tick();
        load  = 1'b0;
        start = 1'b1;
        tick();
        lap = 1'b1;
        tick();
        check("lap_count", {24'd0, count2}, 32'h13);
        check("lap_disp", {24'd0, disp2}, 32'h12);
        for (int k = 0; k < 7; k++) tick();
        check("lap_count_20", {24'd0, count2}, 32'h20);
        check("lap_disp_20", {24'd0, disp2}, 32'h12);
        lap = 1'b0;
        tick();
        lap = 1'b1;
        tick();
        check("lap_clear", {24'd0, disp2}, 32'h22);
        lap = 1'b0;
        tick();
        lap = 1'b1;
        tick();
        check("lap_again", {24'd0, disp2}, 32'h23);
        lv2  = 8'h50;
        load = 1'b1;
        tick();
        check("lap_load_count", {24'd0, count2}, 32'h50);
        check("lap_load_disp", {24'd0, disp2}, 32'h50);
        load = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
